// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ctrl_pkg
//  Description : Opcode field patterns, state encoding and decode bundle
//                shared by the control-unit decoder and FSM.
//  Revision    : 1.0 - initial release
// ============================================================================
package ctrl_pkg;

    // FSM state encoding
    localparam logic [1:0] ST_RUN  = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    // Field patterns: OPF_* match a prefix of opcode, OP_* the full 6 bits
    localparam logic       OPF_ALU  = 1'b1;     // opcode[5]
    localparam logic [1:0] OPF_RSVD = 2'b01;    // opcode[5:4]
    localparam logic [3:0] OPF_LI   = 4'b0000;  // opcode[5:2]
    localparam logic [3:0] OPF_WAIT = 4'b0010;  // opcode[5:2]
    localparam logic [3:0] OPF_HALT = 4'b0011;  // opcode[5:2]
    localparam logic [5:0] OP_J     = 6'b000100;
    localparam logic [5:0] OP_JZ    = 6'b000101;
    localparam logic [5:0] OP_JNZ   = 6'b000110;
    localparam logic [5:0] OP_NOP   = 6'b000111;

    typedef struct packed {
        logic       s_inc;
        logic       s_inm;
        logic       we3;
        logic       wez;
        logic [2:0] op_alu;
        logic       is_wait;
        logic       is_halt;
        logic       is_rsvd;
        logic [1:0] wait_n;
    } dec_t;

endpackage
`default_nettype wire

// File: rtl/ctrl_dec.sv
`default_nettype none
// ============================================================================
//  Module      : ctrl_dec
//  Description : Pure combinational opcode decoder for the RUN state.
//  Revision    : 1.0 - initial release
// ============================================================================
module ctrl_dec
    import ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic       z,
    output dec_t       dec
);

    always_comb begin
        dec        = '0;
        dec.s_inc  = 1'b1;
        dec.wait_n = opcode[1:0];
        if (opcode[5] == OPF_ALU) begin
            dec.op_alu = opcode[4:2];
            dec.we3    = 1'b1;
            dec.wez    = 1'b1;
        end else if (opcode[5:4] == OPF_RSVD) begin
            dec.is_rsvd = 1'b1;
        end else if (opcode[5:2] == OPF_LI) begin
            dec.we3   = 1'b1;
            dec.s_inm = 1'b1;
        end else if (opcode[5:2] == OPF_WAIT) begin
            dec.is_wait = 1'b1;
        end else if (opcode[5:2] == OPF_HALT) begin
            dec.is_halt = 1'b1;
        end else begin
            // Remaining 0001xx space: jumps and NOP
            case (opcode)
                OP_J:    dec.s_inc = 1'b0;
                OP_JZ:   dec.s_inc = ~z;
                OP_JNZ:  dec.s_inc = z;
                OP_NOP:  dec.s_inc = 1'b1;
                default: dec.s_inc = 1'b1;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/ctrl_unit.sv
`default_nettype none
// ============================================================================
//  Module      : ctrl_unit
//  Description : Processor control unit: RUN/WAIT/HALT FSM, wait counter and
//                sticky illegal-opcode flag around the opcode decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
module ctrl_unit
    import ctrl_pkg::*;
#(
    parameter int HALT_ON_ILLEGAL = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       z,
    output logic       s_inc,
    output logic       s_inm,
    output logic       we3,
    output logic       wez,
    output logic [2:0] op_alu,
    output logic       pc_we,
    output logic       halted,
    output logic       illegal
);

    localparam logic c_halt_on_ill = (HALT_ON_ILLEGAL != 0);

    logic [1:0] r_state;
    logic [1:0] w_state_next;
    logic [1:0] r_cnt;
    logic [1:0] w_cnt_next;
    logic       r_illegal;
    logic       w_illegal_next;
    logic       w_halt_req;
    dec_t       w_dec;

    ctrl_dec u_dec (
        .opcode (opcode),
        .z      (z),
        .dec    (w_dec)
    );

    assign w_halt_req = w_dec.is_halt | (w_dec.is_rsvd & c_halt_on_ill);
    assign illegal    = r_illegal;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_RUN;
            r_cnt     <= 2'd0;
            r_illegal <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_illegal <= w_illegal_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        w_illegal_next = r_illegal;
        case (r_state)
            ST_RUN: begin
                if (w_dec.is_rsvd) w_illegal_next = 1'b1;
                if (w_dec.is_wait) begin
                    w_state_next = ST_WAIT;
                    w_cnt_next   = w_dec.wait_n;
                end else if (w_halt_req) begin
                    w_state_next = ST_HALT;
                end
            end
            // Count n..0 in WAIT, so WAIT n spans n+2 cycles with its decode cycle
            ST_WAIT: begin
                if (r_cnt == 2'd0) w_state_next = ST_RUN;
                else               w_cnt_next   = r_cnt - 2'd1;
            end
            ST_HALT: w_state_next = ST_HALT;
            default: w_state_next = ST_RUN;
        endcase
    end

    always_comb begin
        s_inc  = 1'b1;
        s_inm  = 1'b0;
        we3    = 1'b0;
        wez    = 1'b0;
        op_alu = 3'b000;
        pc_we  = 1'b0;
        halted = 1'b0;
        if (!reset) begin
            case (r_state)
                ST_RUN: begin
                    s_inc  = w_dec.s_inc;
                    s_inm  = w_dec.s_inm;
                    we3    = w_dec.we3;
                    wez    = w_dec.wez;
                    op_alu = w_dec.op_alu;
                    pc_we  = ~(w_dec.is_wait | w_halt_req);
                end
                ST_WAIT: pc_we  = (r_cnt == 2'd0);
                ST_HALT: halted = 1'b1;
                default: pc_we  = 1'b0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/ctrl_unit.md
CTRL_UNIT -- requirements
Module: ctrl_unit

Interface
REQ-001 SHALL have parameter HALT_ON_ILLEGAL, default 0, meaning: 1 = a reserved opcode enters HALT, 0 = a reserved opcode executes as NOP.
REQ-002 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port opcode, input, 6 bits: instruction bits [15:10] from the datapath.
REQ-005 SHALL have port z, input, 1 bit: registered zero flag from the datapath.
REQ-006 SHALL have port s_inc, output, 1 bit: 1 = next PC is PC+1, 0 = next PC is the jump address in instruction bits [9:0].
REQ-007 SHALL have port s_inm, output, 1 bit: 1 = register write data is the immediate in bits [11:4], 0 = ALU result.
REQ-008 SHALL have port we3, output, 1 bit: register-file write enable.
REQ-009 SHALL have port wez, output, 1 bit: zero-flag write enable.
REQ-010 SHALL have port op_alu, output, 3 bits: ALU operation select.
REQ-011 SHALL have port pc_we, output, 1 bit: PC load enable; 0 holds the PC.
REQ-012 SHALL have port halted, output, 1 bit: 1 while in HALT.
REQ-013 SHALL have port illegal, output, 1 bit: sticky flag, set on any reserved opcode.

Function
REQ-014 SHALL implement a state machine with three states: RUN, WAIT, HALT.
REQ-015 In RUN, SHALL decode opcode combinationally with zero latency and set pc_we=1, except for WAIT and HALT instructions and HALT_ON_ILLEGAL=1 reserved opcodes, where pc_we=0.
REQ-016 opcode[5]=1 (ALU): SHALL drive op_alu=opcode[4:2], we3=1, wez=1, s_inm=0, s_inc=1.
REQ-017 opcode[5:2]=0000 (LI): SHALL drive we3=1, s_inm=1, wez=0, s_inc=1.
REQ-018 opcode=000100 (J): SHALL drive s_inc=0 with no writes.
REQ-019 opcode=000101 (JZ): SHALL drive s_inc=~z; opcode=000110 (JNZ): SHALL drive s_inc=z; both with no writes.
REQ-020 opcode=000111 (NOP): SHALL drive s_inc=1 with no writes.
REQ-021 opcode[5:2]=0010 (WAIT n, n=opcode[1:0]): SHALL load a 2-bit counter with n, go to WAIT, and hold pc_we=0.
REQ-022 In WAIT: SHALL hold pc_we=0, we3=0, wez=0, and decrement the counter each cycle; at count 0 SHALL return to RUN with pc_we=1 and s_inc=1.
REQ-023 The WAIT instruction SHALL occupy exactly n+2 cycles in total.
REQ-024 opcode[5:2]=0011 (HALT): SHALL go to HALT next cycle with pc_we=0.
REQ-025 In HALT: SHALL drive pc_we=0, we3=0, wez=0, halted=1, and leave HALT only on reset.
REQ-026 opcode[5:4]=01 (reserved): SHALL set illegal; SHALL execute as NOP if HALT_ON_ILLEGAL=0, or behave as HALT if HALT_ON_ILLEGAL=1.
REQ-027 illegal SHALL clear only on reset.
REQ-028 When opcode is don't-care, op_alu SHALL be 000.
REQ-029 Jumps SHALL use the registered z, so an ALU instruction immediately preceding a JZ determines that JZ's outcome.

Reset
REQ-030 reset SHALL asynchronously force state=RUN, counter=0, illegal=0.
REQ-031 While reset is high, SHALL force we3=0, wez=0, pc_we=0, s_inc=1, s_inm=0, op_alu=000, halted=0.
REQ-032 Reset asserted mid-WAIT or in HALT SHALL abort it; the first cycle after release SHALL decode in RUN.

Structure
REQ-033 Package ctrl_pkg SHALL hold the opcode constants (ALU, LI, J, JZ, JNZ, NOP, WAIT, HALT field patterns) and the 2-bit state encoding.
REQ-034 The pure combinational opcode decoder SHALL be sub-module ctrl_dec; the FSM, wait counter and illegal flag SHALL reside in ctrl_unit.

Verification
REQ-035 Release reset, apply opcode=100100 -> op_alu=001, we3=1, wez=1, s_inc=1, pc_we=1.
REQ-036 Apply opcode=000101 with z=1 -> s_inc=0; with z=0 -> s_inc=1; we3=wez=0 in both cases.
REQ-037 Apply opcode=001011 (WAIT 3) -> pc_we=0 for 4 cycles, then pc_we=1 on the 5th cycle; we3=0 throughout.
REQ-038 Apply opcode=001100 -> halted=1 and pc_we=0 from the next cycle, held for 20 cycles of arbitrary opcodes; reset -> halted=0.
REQ-039 Apply opcode=010000 with HALT_ON_ILLEGAL=0 -> illegal=1, pc_we=1, no writes; with HALT_ON_ILLEGAL=1 -> halted=1.
REQ-040 Assert reset in the 2nd cycle of WAIT 3 -> all enables 0 immediately; after release, state=RUN and the next opcode executes.
